switch_port_mc: RTL and testbench
=================================

# switch_port_mc

Parametrised ingress port for the N-port packet switch, the generalisation of the fixed 4-port switch port. It buffers incoming packets in a local FIFO and classifies the head packet as single-, multi- or broadcast-destination. It then requests one output per destination from the arbiters and serves multicast packets across partial grants, popping a packet only after every destination has been served. Illegal packets are dropped and counted.

## Interface
- NUM_PORTS, 4, switch port count; width of the source, target, request and grant vectors
- DATA_W, 8, payload width
- DEPTH, 8, FIFO depth in packets, power of two, ≥2
- TIMEOUT_CYCLES, 16, arbitration watchdog limit (used only with SWITCH_PORT_MC_TIMEOUT_EN)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  packet write strobe
- ready_in  out  1  FIFO not full; a write is accepted only when valid_in && ready_in
- source_in  in  NUM_PORTS  one-hot source port
- target_in  in  NUM_PORTS  destination mask
- data_in  in  DATA_W  payload
- req  out  NUM_PORTS  per-destination request to the output arbiters
- grant  in  NUM_PORTS  per-destination grant; bits outside req are ignored
- valid_out  out  1  transmit beat
- source_out  out  NUM_PORTS  head packet source
- target_out  out  NUM_PORTS  destinations served on this beat
- data_out  out  DATA_W  head packet payload
- drop_cnt  out  8  count of dropped packets, saturating at 255
- timeout  out  1  one-cycle pulse on a watchdog drop

## Operation
- FIFO stores {data, target, source}. It is written on an accepted valid_in and popped only by the FSM.
- Legality rules:
  - source must be exactly one-hot.
  - target must be nonzero.
  - (target & source) must be 0.
  - Any packet failing these rules is ERR.
- Packet type: SDP if popcount(target)=1; BDP if target == ~source; MDP otherwise.
- FSM states: IDLE, ROUTE, ARB_WAIT, TRANSMIT.
  - IDLE: if FIFO is not empty → ROUTE.
  - ROUTE: classify the head packet.
    - ERR: pop, increment drop_cnt, → IDLE.
    - Otherwise: pending ← target, latch the type, → ARB_WAIT.
  - ARB_WAIT: req = pending.
    - If (grant & pending) ≠ 0: served ← grant & pending, → TRANSMIT.
    - Otherwise stay.
  - TRANSMIT: valid_out=1, target_out=served, source_out and data_out from the head packet, pending ← pending & ~served.
    - If the new pending is 0: pop, → IDLE.
    - Otherwise → ARB_WAIT.
- req is 0 in every state except ARB_WAIT.
- source_out, target_out and data_out are 0 whenever valid_out=0.
- An SDP packet always completes in a single TRANSMIT. An MDP or BDP packet may take up to popcount(target) TRANSMIT beats.

## Timing
- Reset values: state IDLE, FIFO empty, ready_in=1, req=0, valid_out=0, all data outputs 0, drop_cnt=0, timeout=0.
- Reset mid-packet discards the FIFO contents and pending state. No beat is emitted in the cycle after reset.
- All outputs are registered or decoded from registered state. Grant-to-beat latency is 1 cycle.
- Minimum latency from write edge E0: ROUTE at E1, ARB_WAIT at E2 (req visible), TRANSMIT at E3 if grant is present in the E2–E3 cycle. valid_out is high in the cycle after E3.
- Back-to-back SDP packets occupy 4 cycles each: IDLE, ROUTE, ARB_WAIT, TRANSMIT.
- ready_in = !full. A write while full is ignored, including a write in the same cycle as a pop; it is not counted as a drop.
- A simultaneous write and pop when not full both take effect, leaving the occupancy unchanged.
- Read and write pointers wrap modulo DEPTH. full and empty are derived from an extra pointer bit.
- drop_cnt holds at 255.

## Configuration
- SWITCH_PORT_MC_TIMEOUT_EN defined: a counter runs while in ARB_WAIT and clears on every partial grant and on leaving ARB_WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no grant, the remaining destinations are abandoned: pop, drop_cnt+1, timeout pulses for 1 cycle, → IDLE.
  - Packets already partially served count as dropped.
- Undefined: ARB_WAIT waits indefinitely and timeout is tied to 0.

## Test plan
- Write SDP src=0001 tgt=0100 data=0xA5, hold grant=0100 → req=0100 after E2, one beat valid_out=1, target_out=0100, data_out=0xA5, FIFO empty.
- Write BDP src=0001 tgt=1110 data=0x3C, grant 0010, then 1000, then 0100 on successive ARB_WAIT cycles → three beats with target_out 0010, 1000, 0100, then a single pop.
- Write illegal packets tgt=0000, src=0011, and src=0001 tgt=0001 → no req, no beat, drop_cnt=3.
- Write 9 packets back-to-back with grant=0 → ready_in=0 after 8 writes, the 9th is ignored; after grants, exactly 8 beats emerge in order.
- Assert rst while in ARB_WAIT with 3 packets queued → next cycle req=0, ready_in=1, FIFO empty, drop_cnt=0.
- With SWITCH_PORT_MC_TIMEOUT_EN, SDP tgt=0010 with grant=0 for 16 cycles → timeout pulse, drop_cnt=1, no beat, return to IDLE.

Source files
------------

// File: rtl/switch_port_mc_if.sv
// Ingress/egress bus of one switch port: packet write side plus arbiter request/grant and
// transmit beat. The slave modport is the port itself; master is the environment.
interface switch_port_mc_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 8
);
    logic                 valid_in;
    logic                 ready_in;
    logic [NUM_PORTS-1:0] source_in;
    logic [NUM_PORTS-1:0] target_in;
    logic [DATA_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant;
    logic                 valid_out;
    logic [NUM_PORTS-1:0] source_out;
    logic [NUM_PORTS-1:0] target_out;
    logic [DATA_W-1:0]    data_out;

    modport slave (
        input  valid_in, source_in, target_in, data_in, grant,
        output ready_in, req, valid_out, source_out, target_out, data_out
    );

    modport master (
        output valid_in, source_in, target_in, data_in, grant,
        input  ready_in, req, valid_out, source_out, target_out, data_out
    );
endinterface

// File: rtl/switch_port_mc.sv
// N-port switch ingress: packet FIFO, legality check and multicast serving across partial grants.
// Optional arbitration watchdog enabled by defining SWITCH_PORT_MC_TIMEOUT_EN.
module switch_port_mc #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    switch_port_mc_if.slave  bus,
    output logic [7:0]       drop_cnt,
    output logic             timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_W + 2 * NUM_PORTS;
    localparam logic [AW:0]          PtrOne  = 1;
    localparam logic [NUM_PORTS-1:0] PortOne = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two no smaller than 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StRoute, StArbWait, StTransmit} state_e;
    typedef enum logic [1:0] {PktSdp, PktMdp, PktBdp} pkt_e;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 full, empty, push, pop;
    logic [NUM_PORTS-1:0] head_src, head_tgt;
    logic [DATA_W-1:0]    head_data;
    logic                 head_err;
    pkt_e                 head_type;

    state_e               state_q;
    logic [NUM_PORTS-1:0] pending_q, served_q, pending_left, granted;
    pkt_e                 pkt_type_q;
    logic [7:0]           drop_cnt_q;
    logic                 tmo_drop;
    logic                 done;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.valid_in && !full;
    assign {head_data, head_tgt, head_src} = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.data_in, bus.target_in, bus.source_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_comb begin
        head_err = (head_src == '0) || ((head_src & (head_src - PortOne)) != '0) ||
                   (head_tgt == '0) || ((head_tgt & head_src) != '0);
        if ($countones(head_tgt) == 1) begin
            head_type = PktSdp;
        end else if (head_tgt == ~head_src) begin
            head_type = PktBdp;
        end else begin
            head_type = PktMdp;
        end
    end

    assign granted      = bus.grant & pending_q;
    assign pending_left = pending_q & ~served_q;
    assign done         = (pending_left == '0) || (pkt_type_q == PktSdp);
    assign pop          = (state_q == StRoute && head_err) ||
                          (state_q == StTransmit && done) || tmo_drop;

`ifdef SWITCH_PORT_MC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;

    assign tmo_drop = (state_q == StArbWait) && (granted == '0) &&
                      (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_drop;
            if (state_q == StArbWait && granted == '0 && !tmo_drop) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end
    assign timeout = timeout_q;
`else
    assign tmo_drop = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            served_q   <= '0;
            pkt_type_q <= PktSdp;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!empty) state_q <= StRoute;
                end
                StRoute: begin
                    if (head_err) begin
                        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                        state_q <= StIdle;
                    end else begin
                        pending_q  <= head_tgt;
                        pkt_type_q <= head_type;
                        state_q    <= StArbWait;
                    end
                end
                StArbWait: begin
                    if (granted != '0) begin
                        served_q <= granted;
                        state_q  <= StTransmit;
                    end else if (tmo_drop) begin
                        // Partially served packets still count as dropped.
                        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                        pending_q <= '0;
                        state_q   <= StIdle;
                    end
                end
                StTransmit: begin
                    pending_q <= done ? '0 : pending_left;
                    state_q   <= done ? StIdle : StArbWait;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_in   = !full;
    assign bus.req        = (state_q == StArbWait) ? pending_q : '0;
    assign bus.valid_out  = (state_q == StTransmit);
    assign bus.target_out = bus.valid_out ? served_q : '0;
    assign bus.source_out = bus.valid_out ? head_src : '0;
    assign bus.data_out   = bus.valid_out ? head_data : '0;
    assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_switch_port_mc.sv
// Directed bench for switch_port_mc: SDP, BDP across partial grants, illegal drops, FIFO full,
// reset mid-packet, watchdog (when SWITCH_PORT_MC_TIMEOUT_EN is defined) and drop_cnt saturation.
module tb_switch_port_mc;
    localparam int unsigned NP    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drop_cnt;
    logic       timeout;
    int         checks   = 0;
    int         failures = 0;

    switch_port_mc_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    switch_port_mc #(
        .NUM_PORTS      (NP),
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        bus.valid_in  = 1'b1;
        bus.source_in = s;
        bus.target_in = t;
        bus.data_in   = d;
        step();
        bus.valid_in  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int beats;
        int bad;

        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.source_in = '0;
        bus.target_in = '0;
        bus.data_in   = '0;
        bus.grant     = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", bus.ready_in, 1);
        chk("rst_req", bus.req, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_outs", {bus.source_out, bus.target_out, bus.data_out}, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_timeout", timeout, 0);

        // SDP with grant held: E0 write, E1 route, E2 req, E3 beat
        bus.grant = 4'b0100;
        wr(4'b0001, 4'b0100, 8'hA5);
        step();
        chk("sdp_route_req", bus.req, 0);
        step();
        chk("sdp_req", bus.req, 4'b0100);
        step();
        chk("sdp_valid", bus.valid_out, 1);
        chk("sdp_target", bus.target_out, 4'b0100);
        chk("sdp_data", bus.data_out, 8'hA5);
        chk("sdp_source", bus.source_out, 4'b0001);
        step();
        chk("sdp_after_valid", bus.valid_out, 0);
        chk("sdp_after_outs", {bus.source_out, bus.target_out, bus.data_out}, 0);
        step();
        step();
        chk("sdp_empty_req", bus.req, 0);
        chk("sdp_empty_valid", bus.valid_out, 0);
        bus.grant = '0;

        // BDP served over three partial grants, with an out-of-request grant ignored
        wr(4'b0001, 4'b1110, 8'h3C);
        step();
        step();
        chk("bdp_req0", bus.req, 4'b1110);
        bus.grant = 4'b0010;
        step();
        chk("bdp_beat0_target", bus.target_out, 4'b0010);
        chk("bdp_beat0_data", bus.data_out, 8'h3C);
        bus.grant = 4'b0011;
        step();
        chk("bdp_req1", bus.req, 4'b1100);
        step();
        chk("bdp_ignored_grant_req", bus.req, 4'b1100);
        chk("bdp_ignored_grant_valid", bus.valid_out, 0);
        bus.grant = 4'b1000;
        step();
        chk("bdp_beat1_target", bus.target_out, 4'b1000);
        bus.grant = 4'b0000;
        step();
        chk("bdp_req2", bus.req, 4'b0100);
        bus.grant = 4'b0100;
        step();
        chk("bdp_beat2_target", bus.target_out, 4'b0100);
        chk("bdp_beat2_source", bus.source_out, 4'b0001);
        bus.grant = 4'b0000;
        step();
        chk("bdp_done_valid", bus.valid_out, 0);
        step();
        step();
        chk("bdp_single_pop_req", bus.req, 0);

        // Illegal packets: empty target, two-hot source, target overlapping source
        bus.grant = 4'b1111;
        wr(4'b0001, 4'b0000, 8'h11);
        wr(4'b0011, 4'b0100, 8'h22);
        wr(4'b0001, 4'b0001, 8'h33);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.req !== '0 || bus.valid_out !== 1'b0) bad++;
            step();
        end
        chk("illegal_quiet", bad, 0);
        chk("illegal_drop_cnt", drop_cnt, 3);
        bus.grant = '0;

        // Fill: 9 writes with no grant, 9th ignored, then 8 beats in order
        for (int i = 0; i < 9; i++) begin
            chk("fill_ready", bus.ready_in, (i < 8) ? 1 : 0);
            wr(4'b0001, 4'b0010, 8'(8'h10 + i));
        end
        chk("full_ready", bus.ready_in, 0);
        bus.grant = 4'b0010;
        beats = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus.valid_out === 1'b1) begin
                chk("fill_beat_data", bus.data_out, 8'h10 + beats);
                beats++;
            end
        end
        chk("fill_beat_count", beats, 8);
        chk("fill_ready_after", bus.ready_in, 1);
        bus.grant = '0;

        // Reset while in ARB_WAIT with three packets queued
        wr(4'b0001, 4'b0010, 8'h41);
        wr(4'b0001, 4'b0010, 8'h42);
        wr(4'b0001, 4'b0010, 8'h43);
        step();
        chk("pre_rst_req", bus.req, 4'b0010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_req", bus.req, 0);
        chk("mid_rst_ready", bus.ready_in, 1);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_valid", bus.valid_out, 0);
        bus.grant = 4'b1111;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.valid_out === 1'b1) beats++;
        end
        chk("mid_rst_flushed", beats, 0);
        bus.grant = '0;

`ifdef SWITCH_PORT_MC_TIMEOUT_EN
        wr(4'b0001, 4'b0010, 8'h77);
        step();
        step();
        chk("tmo_req", bus.req, 4'b0010);
        n = 0;
        bad = 0;
        while (timeout !== 1'b1 && n < 40) begin
            step();
            n++;
            if (bus.valid_out !== 1'b0) bad++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_no_beat", bad, 0);
        chk("tmo_drop_cnt", drop_cnt, 1);
        chk("tmo_req_cleared", bus.req, 0);
        step();
        chk("tmo_pulse_end", timeout, 0);
`else
        wr(4'b0001, 4'b0010, 8'h77);
        step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (timeout !== 1'b0) bad++;
        end
        chk("no_tmo_pulse", bad, 0);
        chk("no_tmo_still_waiting", bus.req, 4'b0010);
        bus.grant = 4'b0010;
        step();
        chk("no_tmo_beat", bus.valid_out, 1);
        chk("no_tmo_beat_data", bus.data_out, 8'h77);
        bus.grant = '0;
        step();
`endif

        // drop_cnt saturates at 255
        for (int i = 0; i < 260; i++) begin
            wr(4'b0001, 4'b0000, 8'h00);
            step();
            step();
        end
        chk("drop_saturate", drop_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
